// File: rtl/frame_parity_engine.sv
// frame_parity_engine
//   Streaming parity engine. Beats of DATA_W bits arrive over a valid/ready
//   handshake and are folded into a single parity bit per frame. Odd or even
//   parity and generate or check operation are chosen on the first beat of
//   each frame and held for the rest of it. One result is produced per frame
//   and held until the downstream side accepts it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode_odd   1 = odd parity, 0 = even (taken on the first beat)
//   chk_en     1 = check against s_par_in, 0 = generate (taken on the first beat)
//   s_valid    input beat valid
//   s_ready    block can accept a beat (low only while a result is pending)
//   s_data     input beat
//   s_last     final beat of the frame
//   s_par_in   expected parity, taken with the last beat in check mode
//   m_valid    frame result valid
//   m_ready    downstream accepts the result
//   m_parity   computed parity bit for the frame
//   m_err      check-mode mismatch (always 0 in generate mode)
//   m_beats    beats in the frame, saturating at all-ones
//   err_cnt    running count of check mismatches, saturating
//   err_clr    synchronous clear of err_cnt (wins over an increment)
//   busy       frame open or result pending
module frame_parity_engine #(
  parameter int DATA_W    = 8,
  parameter int BEAT_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode_odd,
  input  logic                 chk_en,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 s_last,
  input  logic                 s_par_in,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_parity,
  output logic                 m_err,
  output logic [BEAT_W-1:0]    m_beats,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                 acc_q, acc_d;
  logic [BEAT_W-1:0]    beats_q, beats_d;
  logic                 mode_q, mode_d;
  logic                 chk_q, chk_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_parity_q, m_parity_d;
  logic                 m_err_q, m_err_d;
  logic [BEAT_W-1:0]    m_beats_q, m_beats_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  function automatic logic [BEAT_W-1:0] beat_inc(input logic [BEAT_W-1:0] v);
    if (&v) return v;
    return v + BEAT_W'(1);
  endfunction

  function automatic logic [ERR_CNT_W-1:0] err_inc(input logic [ERR_CNT_W-1:0] v);
    if (&v) return v;
    return v + ERR_CNT_W'(1);
  endfunction

  // Per-beat helpers. On the first beat of a frame the live mode inputs are
  // used directly, since the latched copies only update on that same edge;
  // this is what lets a single-beat frame resolve with one cycle of latency.
  logic              accept;
  logic              first_beat;
  logic              close_frame;
  logic              beat_par;
  logic              mode_eff;
  logic              chk_eff;
  logic              acc_next;
  logic [BEAT_W-1:0] beats_next;
  logic              par_next;
  logic              err_next;

  assign accept      = s_valid && s_ready;
  assign first_beat  = (state_q == IDLE);
  assign close_frame = accept && s_last;
  assign beat_par    = ^s_data;
  assign mode_eff    = first_beat ? mode_odd : mode_q;
  assign chk_eff     = first_beat ? chk_en   : chk_q;
  assign acc_next    = first_beat ? beat_par : (acc_q ^ beat_par);
  assign beats_next  = first_beat ? BEAT_W'(1) : beat_inc(beats_q);
  assign par_next    = acc_next ^ mode_eff;
  assign err_next    = chk_eff && (par_next != s_par_in);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = s_last ? RESULT : ACC;
      end
      ACC: begin
        if (close_frame) state_d = RESULT;
      end
      RESULT: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    s_ready = (state_q != RESULT);
    busy    = (state_q != IDLE);
  end

  // Frame accumulator and result next-state
  always_comb begin
    acc_d      = acc_q;
    beats_d    = beats_q;
    mode_d     = mode_q;
    chk_d      = chk_q;
    m_valid_d  = m_valid_q;
    m_parity_d = m_parity_q;
    m_err_d    = m_err_q;
    m_beats_d  = m_beats_q;
    err_cnt_d  = err_cnt_q;

    if (accept) begin
      acc_d   = acc_next;
      beats_d = beats_next;
      if (first_beat) begin
        mode_d = mode_odd;
        chk_d  = chk_en;
      end
    end

    if (close_frame) begin
      m_valid_d  = 1'b1;
      m_parity_d = par_next;
      m_err_d    = err_next;
      m_beats_d  = beats_next;
    end else if ((state_q == RESULT) && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (err_clr) begin
      err_cnt_d = '0;
    end else if (close_frame && err_next) begin
      err_cnt_d = err_inc(err_cnt_q);
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= 1'b0;
      beats_q    <= '0;
      mode_q     <= 1'b0;
      chk_q      <= 1'b0;
      m_valid_q  <= 1'b0;
      m_parity_q <= 1'b0;
      m_err_q    <= 1'b0;
      m_beats_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      acc_q      <= acc_d;
      beats_q    <= beats_d;
      mode_q     <= mode_d;
      chk_q      <= chk_d;
      m_valid_q  <= m_valid_d;
      m_parity_q <= m_parity_d;
      m_err_q    <= m_err_d;
      m_beats_q  <= m_beats_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_parity = m_parity_q;
  assign m_err    = m_err_q;
  assign m_beats  = m_beats_q;
  assign err_cnt  = err_cnt_q;

endmodule
